// File: rtl/symbol_counter_pkg.sv
// Shared types and default widths for the symbol histogram block.
package symbol_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    localparam int DEF_S_WIDTH   = 8;
    localparam int DEF_CNT_WIDTH = 8;

endpackage

// File: rtl/symbol_count_cell.sv
// One alphabet entry: latched symbol, match compare and a saturating counter
// with a sticky clip flag.
module symbol_count_cell
    import symbol_counter_pkg::*;
#(
    parameter int S_WIDTH   = DEF_S_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [S_WIDTH-1:0]   load_sym,
    input  logic                 beat,
    input  logic [S_WIDTH-1:0]   beat_sym,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat
);

    logic [S_WIDTH-1:0] sym;
    logic               match;

    assign match = beat && (beat_sym == sym);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym   <= '0;
            count <= '0;
            sat   <= 1'b0;
        end else if (load) begin
            sym   <= load_sym;
            count <= '0;
            sat   <= 1'b0;
        end else if (match) begin
            // At full scale the count holds and the clip is remembered.
            if (count == {CNT_WIDTH{1'b1}})
                sat <= 1'b1;
            else
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/symbol_histogram.sv
// Counts occurrences of N_SYMBOLS alphabet entries over a symbol stream, then
// dumps the per-entry counts through a valid/ready result port.
module symbol_histogram
    import symbol_counter_pkg::*;
#(
    parameter int S_WIDTH   = DEF_S_WIDTH,
    parameter int N_SYMBOLS = 4,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    localparam int IDX_W    = (N_SYMBOLS > 1) ? $clog2(N_SYMBOLS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_SYMBOLS*S_WIDTH-1:0] alphabet,
    input  logic                         in_valid,
    input  logic [S_WIDTH-1:0]           in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_index,
    output logic [CNT_WIDTH-1:0]         out_count,
    output logic                         out_last,
    output logic                         busy,
    output logic                         saturated
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYMBOLS - 1);

    state_t                                state;
    logic                                  load;
    logic                                  beat;
    logic [N_SYMBOLS-1:0][CNT_WIDTH-1:0]   cnt;
    logic [N_SYMBOLS-1:0]                  sat_vec;

    assign load      = (state == ST_IDLE) && start;
    assign in_ready  = (state == ST_COUNT);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state == ST_DUMP);
    assign out_last  = out_valid && (out_index == LAST_IDX);
    assign busy      = (state != ST_IDLE);
    assign saturated = |sat_vec;
    assign out_count = cnt[out_index];

    for (genvar i = 0; i < N_SYMBOLS; i++) begin : g_cell
        symbol_count_cell #(
            .S_WIDTH  (S_WIDTH),
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .load_sym(alphabet[i*S_WIDTH +: S_WIDTH]),
            .beat    (beat),
            .beat_sym(in_data),
            .count   (cnt[i]),
            .sat     (sat_vec[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_COUNT;
                end
                ST_COUNT: begin
                    out_index <= '0;
                    if (beat && in_last)
                        state <= ST_DUMP;
                end
                ST_DUMP: begin
                    if (out_ready) begin
                        if (out_index == LAST_IDX) begin
                            state     <= ST_IDLE;
                            out_index <= '0;
                        end else begin
                            out_index <= out_index + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_symbol_histogram.sv
// Directed and randomized runs of symbol_histogram checked against a
// count-by-scan reference model.
module tb_symbol_histogram;

    localparam int SW = 8;
    localparam int NS = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NS*SW-1:0]  alphabet = '0;
    logic              in_valid = 1'b0;
    logic [SW-1:0]     in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_index;
    logic [CW-1:0]     out_count;
    logic              out_last;
    logic              busy;
    logic              saturated;

    symbol_histogram #(.S_WIDTH(SW), .N_SYMBOLS(NS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alphabet(alphabet),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_count(out_count), .out_last(out_last), .busy(busy), .saturated(saturated)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  alph [NS];
    logic [7:0]  syms [$];
    int          exp_cnt [NS];
    bit          exp_sat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each entry counts every symbol equal to it, clipped at CMAX.
    task automatic model();
        exp_sat = 1'b0;
        for (int i = 0; i < NS; i++) begin
            int raw = 0;
            foreach (syms[k]) if (syms[k] == alph[i]) raw++;
            exp_cnt[i] = (raw > CMAX) ? CMAX : raw;
            if (raw > CMAX) exp_sat = 1'b1;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        for (int i = 0; i < NS; i++) alphabet[i*SW +: SW] = alph[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        alphabet = {$urandom, $urandom};
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic send_beat(input logic [7:0] sym, input bit last, input bit poke);
        int guard = 0;
        int gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = sym;
        in_last  = last;
        if (poke) begin
            start = 1'b1;
            for (int i = 0; i < NS; i++) alphabet[i*SW +: SW] = sym;
        end
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic dump(input int stall_max, input bit poke);
        int guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("dump_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < NS; i++) begin
            int stall = $urandom_range(0, stall_max);
            if (poke && i == 1) begin
                alphabet = '0;
                start = 1'b1;
            end
            for (int s = 0; s <= stall; s++) begin
                check($sformatf("idx%0d_s%0d", i, s), 32'(out_index), 32'(i));
                check($sformatf("cnt%0d_s%0d", i, s), 32'(out_count), 32'(exp_cnt[i]));
                check($sformatf("last%0d_s%0d", i, s), 32'(out_last), 32'(i == NS - 1));
                check($sformatf("ov%0d_s%0d", i, s), 32'(out_valid), 32'd1);
                if (s < stall) @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            start = 1'b0;
        end
        check("post_busy", 32'(busy), 32'd0);
        check("post_ov", 32'(out_valid), 32'd0);
        check("post_olast", 32'(out_last), 32'd0);
        check("post_sat", 32'(saturated), 32'(exp_sat));
        repeat (2) @(negedge clk);
        check("idle_sat_hold", 32'(saturated), 32'(exp_sat));
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run(input int stall_max, input bit poke);
        model();
        do_start();
        foreach (syms[k]) send_beat(syms[k], k == syms.size() - 1, poke && k == 0);
        dump(stall_max, poke);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_index), 32'd0);
        check("rst_sat", 32'(saturated), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic "ABCA"
        alph = '{8'h41, 8'h42, 8'h43, 8'h44};
        syms = '{8'h41, 8'h42, 8'h43, 8'h41};
        run(0, 1'b0);

        // Same run under output backpressure
        run(3, 1'b0);

        // Saturation
        syms.delete();
        repeat (20) syms.push_back(8'h41);
        run(1, 1'b0);

        // Duplicates and misses
        alph = '{8'h41, 8'h41, 8'h5A, 8'h00};
        syms = '{8'h41, 8'h58, 8'h41};
        run(1, 1'b0);

        // start pulsed during COUNT and DUMP is ignored
        alph = '{8'h41, 8'h42, 8'h43, 8'h44};
        syms = '{8'h42, 8'h42, 8'h44};
        run(2, 1'b1);

        // Reset in the middle of COUNT
        syms = '{8'h41, 8'h42};
        do_start();
        send_beat(8'h41, 1'b0, 1'b0);
        send_beat(8'h42, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_idx", 32'(out_index), 32'd0);
        check("mid_rst_cnt", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h41;
        repeat (3) @(negedge clk);
        check("no_resume_busy", 32'(busy), 32'd0);
        check("no_resume_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        syms = '{8'h42};
        run(1, 1'b0);

        // Randomized runs over a narrow symbol range so matches and clips occur
        for (int r = 0; r < 8; r++) begin
            int len = $urandom_range(1, 24);
            for (int i = 0; i < NS; i++) alph[i] = 8'(8'h41 + $urandom_range(0, 3));
            syms.delete();
            for (int k = 0; k < len; k++) syms.push_back(8'(8'h41 + $urandom_range(0, 4)));
            run(3, r[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
